// File: rtl/byte_fetch_if.sv
// Byte-wide instruction memory read port used by byte_fetch.
interface byte_fetch_if #(
    parameter int unsigned AW = 64
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [7:0]    imem_data;
    logic          imem_error;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data, imem_error
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data, imem_error
    );
endinterface

// File: rtl/byte_fetch.sv
// Y86-style instruction fetch: reads 1..10 bytes one at a time and decodes the fields.
// Optional macro FETCH_IFUN_CHECK_EN additionally flags illegal ifun values as invalid.
module byte_fetch #(
    parameter int unsigned AW = 64
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [AW-1:0]   pc,
    input  logic            start,
    byte_fetch_if.master    imem,
    output logic            busy,
    output logic            done,
    output logic [3:0]      icode,
    output logic [3:0]      ifun,
    output logic [3:0]      rA,
    output logic [3:0]      rB,
    output logic [63:0]     valC,
    output logic [AW-1:0]   valP,
    output logic            instr_valid,
    output logic            instr_invalid,
    output logic            imem_err
);

    localparam logic [3:0] NO_REG = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_BYTE0, S_REGS, S_CONST, S_DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] pc_q;
    logic [2:0]    cnt;
    logic          inv_next;

    function automatic logic has_regs(input logic [3:0] ic);
        return ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    endfunction

    function automatic logic has_const(input logic [3:0] ic);
        return ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    endfunction

    // Total instruction length in bytes; C-F fall out as 1 byte.
    function automatic logic [3:0] len_of(input logic [3:0] ic);
        return 4'd1 + (has_regs(ic) ? 4'd1 : 4'd0) + (has_const(ic) ? 4'd8 : 4'd0);
    endfunction

    function automatic logic is_invalid(input logic [7:0] b);
        logic bad;
        bad = (b[7:4] >= 4'hC);
`ifdef FETCH_IFUN_CHECK_EN
        unique case (b[7:4])
            4'h2, 4'h7: bad = bad || (b[3:0] > 4'd6);
            4'h6:       bad = bad || (b[3:0] > 4'd3);
            4'hC, 4'hD, 4'hE, 4'hF: bad = 1'b1;
            default:    bad = bad || (b[3:0] != 4'd0);
        endcase
`endif
        return bad;
    endfunction

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a byte is consumed only on an ack edge
    always_comb begin
        state_next = state;
        inv_next   = instr_invalid;
        unique case (state)
            S_IDLE:  if (start) state_next = S_BYTE0;
            S_BYTE0: if (imem.imem_ack) begin
                if (imem.imem_error) begin
                    state_next = S_DONE;
                end else begin
                    inv_next = is_invalid(imem.imem_data);
                    if (has_regs(imem.imem_data[7:4]))       state_next = S_REGS;
                    else if (has_const(imem.imem_data[7:4])) state_next = S_CONST;
                    else                                     state_next = S_DONE;
                end
            end
            S_REGS:  if (imem.imem_ack)
                state_next = (!imem.imem_error && has_const(icode)) ? S_CONST : S_DONE;
            S_CONST: if (imem.imem_ack && (imem.imem_error || cnt == 3'd7))
                state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath, memory request and status registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= '0;
            pc_q           <= '0;
            cnt            <= 3'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            icode          <= 4'h0;
            ifun           <= 4'h0;
            rA             <= NO_REG;
            rB             <= NO_REG;
            valC           <= 64'h0;
            valP           <= '0;
            instr_valid    <= 1'b0;
            instr_invalid  <= 1'b0;
            imem_err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && start) begin
                pc_q           <= pc;
                imem.imem_addr <= pc;
                imem.imem_req  <= 1'b1;
                cnt            <= 3'd0;
                busy           <= 1'b1;
                instr_valid    <= 1'b0;
                instr_invalid  <= 1'b0;
                imem_err       <= 1'b0;
            end
            if (imem.imem_ack && (state == S_BYTE0 || state == S_REGS || state == S_CONST)) begin
                if (imem.imem_error) begin
                    imem_err <= 1'b1;
                end else if (state == S_BYTE0) begin
                    icode         <= imem.imem_data[7:4];
                    ifun          <= imem.imem_data[3:0];
                    rA            <= NO_REG;
                    rB            <= NO_REG;
                    valC          <= 64'h0;
                    valP          <= pc_q + AW'(len_of(imem.imem_data[7:4]));
                    instr_invalid <= inv_next;
                end else if (state == S_REGS) begin
                    rA <= imem.imem_data[7:4];
                    rB <= imem.imem_data[3:0];
                end else begin
                    valC[{cnt, 3'b000} +: 8] <= imem.imem_data;
                    cnt                      <= cnt + 3'd1;
                end
                if (state_next == S_DONE) begin
                    imem.imem_req <= 1'b0;
                    done          <= 1'b1;
                    instr_valid   <= !inv_next && !imem.imem_error;
                end else begin
                    imem.imem_addr <= imem.imem_addr + AW'(1);
                end
            end
            if (state == S_DONE) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_fetch.sv
// Self-checking bench for byte_fetch: memory responder, fetch reference model, directed and random scenarios.
module tb_byte_fetch;
    localparam int unsigned AW = 64;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [AW-1:0] pc_in;
    logic          busy, done, instr_valid, instr_invalid, imem_err;
    logic [3:0]    icode, ifun, rA, rB;
    logic [63:0]   valC;
    logic [AW-1:0] valP;

    byte_fetch_if #(.AW(AW)) bus ();

    byte_fetch #(.AW(AW)) dut (
        .Clk(Clk), .Reset(Reset), .pc(pc_in), .start(start), .imem(bus),
        .busy(busy), .done(done), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_valid(instr_valid),
        .instr_invalid(instr_invalid), .imem_err(imem_err)
    );

    always #5 Clk = ~Clk;

    int            checks = 0;
    int            failures = 0;
    longint        cyc = 0;
    longint        last_ack_cyc = 0;
    int            acks_total = 0;
    int            hold_viol = 0;
    logic [AW-1:0] ack_q[$];
    logic [7:0]    mem[logic [AW-1:0]];
    int            ack_mode = 0;
    int            err_at = -1;
    logic          hold_pend = 1'b0;
    logic [AW-1:0] hold_addr = '0;

    int            base_ack;
    longint        c0;
    longint        done_rel;
    logic          got_done;

    // Handshake monitor: records accepted addresses and checks request hold while stalled
    always @(posedge Clk) begin
        if (bus.imem_req && bus.imem_ack) begin
            ack_q.push_back(bus.imem_addr);
            acks_total   = acks_total + 1;
            last_ack_cyc = cyc;
        end
        if (hold_pend && !Reset && (!bus.imem_req || bus.imem_addr !== hold_addr))
            hold_viol = hold_viol + 1;
        hold_pend = bus.imem_req && !bus.imem_ack && !Reset;
        hold_addr = bus.imem_addr;
        cyc = cyc + 1;
    end

    // Memory responder driven on the falling edge
    initial begin
        logic tgl, a;
        tgl = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_data  = 8'h00;
        bus.imem_error = 1'b0;
        forever begin
            @(negedge Clk);
            case (ack_mode)
                0:       a = 1'b1;
                1:       a = tgl;
                default: a = 1'($urandom_range(0, 1));
            endcase
            tgl = ~tgl;
            bus.imem_ack   = a;
            bus.imem_data  = mem.exists(bus.imem_addr) ? mem[bus.imem_addr] : 8'h00;
            bus.imem_error = a && bus.imem_req && (acks_total == err_at);
        end
    end

    // Reference model: fields after 'ok' bytes have been delivered without error
    task automatic model(input logic [AW-1:0] p, input logic [79:0] b, input int ok,
                         output int len, output logic [3:0] ra, output logic [3:0] rb,
                         output logic [63:0] vc, output logic [AW-1:0] vp, output logic inv);
        logic [3:0] ic, fn, lim;
        logic regs, cst;
        int off;
        ic = b[7:4];
        fn = b[3:0];
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        regs = (len == 2) || (len == 10);
        cst  = (len >= 9);
        ra = (regs && ok >= 2) ? b[15:12] : 4'hF;
        rb = (regs && ok >= 2) ? b[11:8]  : 4'hF;
        off = regs ? 2 : 1;
        vc = 64'h0;
        if (cst)
            for (int k = 0; k < 8; k++)
                if (off + k < ok) vc[8*k +: 8] = b[8*(off+k) +: 8];
        vp  = p + AW'(len);
        inv = (ic >= 4'hC);
        lim = (ic == 4'h2 || ic == 4'h7) ? 4'd6 : (ic == 4'h6) ? 4'd3 : 4'd0;
`ifdef FETCH_IFUN_CHECK_EN
        inv = inv || (fn > lim);
`else
        if (fn > lim) inv = inv;
`endif
    endtask

    task automatic run_fetch(input logic [AW-1:0] p, input logic [79:0] b,
                             input int mode, input int eidx);
        for (int i = 0; i < 10; i++) mem[p + AW'(i)] = b[8*i +: 8];
        ack_mode = mode;
        @(negedge Clk);
        base_ack = acks_total;
        err_at   = (eidx >= 0) ? acks_total + eidx : -1;
        pc_in    = p;
        start    = 1'b1;
        c0       = cyc;
        @(negedge Clk);
        start    = 1'b0;
        got_done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        done_rel = cyc - c0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b0; pc_in = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({bus.imem_req, bus.imem_addr, busy, done, icode, ifun, rA, rB, valC, valP,
             instr_valid, instr_invalid, imem_err} !==
            {1'b0, 64'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got req=%b addr=%h busy=%b done=%b ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h v=%b i=%b e=%b",
                     bus.imem_req, bus.imem_addr, busy, done, icode, ifun, rA, rB, valC, valP,
                     instr_valid, instr_invalid, imem_err);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_one_byte();
        run_fetch(64'h100, 80'h10, 0, -1);
        checks++;
        if (!got_done || done_rel != 2) begin
            failures++; $display("FAIL nop1_latency got done=%b cycle=%0d exp cycle=2", got_done, done_rel);
        end
        checks++;
        if ({icode, ifun, rA, rB, valC, valP, instr_valid, busy} !==
            {4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL nop1_fields got ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h v=%b busy=%b exp 1 0 F F 0 101 1 1",
                     icode, ifun, rA, rB, valC, valP, instr_valid, busy);
        end
        @(negedge Clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++; $display("FAIL done_pulse got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_irmovq_long();
        run_fetch(64'h0, 80'h0123456789ABCDEFF030, 0, -1);
        checks++;
        if (!got_done || done_rel != 11) begin
            failures++; $display("FAIL len10_latency got done=%b cycle=%0d exp 11", got_done, done_rel);
        end
        checks++;
        if ({icode, rA, rB, valC, valP, instr_valid} !==
            {4'h3, 4'hF, 4'h0, 64'h0123456789ABCDEF, 64'hA, 1'b1}) begin
            failures++;
            $display("FAIL len10_fields got ic=%h rA=%h rB=%h valC=%h valP=%h v=%b exp 3 F 0 0123456789abcdef a 1",
                     icode, rA, rB, valC, valP, instr_valid);
        end
    endtask

    task automatic test_stall();
        int hv0;
        hv0 = hold_viol;
        run_fetch(64'h2000, 80'h0000000000000010_0073, 1, -1);
        checks++;
        if (!got_done || acks_total - base_ack != 9 || done_rel != last_ack_cyc - c0 + 1) begin
            failures++;
            $display("FAIL stall_acks got done=%b acks=%0d done_cycle=%0d last_ack=%0d exp 9 acks done=last+1",
                     got_done, acks_total - base_ack, done_rel, last_ack_cyc - c0);
        end
        checks++;
        if (hold_viol != hv0) begin
            failures++; $display("FAIL stall_addr_hold got violations=%0d exp 0", hold_viol - hv0);
        end
        checks++;
        if ({icode, ifun, valC, valP} !== {4'h7, 4'h3, 64'h1000, 64'h2009}) begin
            failures++; $display("FAIL stall_fields got ic=%h fn=%h valC=%h valP=%h exp 7 3 1000 2009",
                                 icode, ifun, valC, valP);
        end
    endtask

    task automatic test_error();
        run_fetch(64'h300, 80'h1122334455667788_1240, 0, 2);
        checks++;
        if (!got_done || done_rel != 4) begin
            failures++; $display("FAIL err_latency got done=%b cycle=%0d exp 4", got_done, done_rel);
        end
        checks++;
        if ({imem_err, instr_valid, icode, rA, rB, valC} !== {1'b1, 1'b0, 4'h4, 4'h1, 4'h2, 64'h0}) begin
            failures++; $display("FAIL err_fields got e=%b v=%b ic=%h rA=%h rB=%h valC=%h exp 1 0 4 1 2 0",
                                 imem_err, instr_valid, icode, rA, rB, valC);
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (acks_total - base_ack != 3 || bus.imem_req !== 1'b0) begin
            failures++; $display("FAIL err_no_more_req got acks=%0d req=%b exp 3 0",
                                 acks_total - base_ack, bus.imem_req);
        end
    endtask

    task automatic test_invalid();
        logic exp_inv;
        run_fetch(64'h400, 80'hC0, 0, -1);
        checks++;
        if (!got_done || done_rel != 2 || {instr_invalid, instr_valid, valP} !== {1'b1, 1'b0, 64'h401}) begin
            failures++; $display("FAIL invalid_C0 got cycle=%0d i=%b v=%b valP=%h exp 2 1 0 401",
                                 done_rel, instr_invalid, instr_valid, valP);
        end
`ifdef FETCH_IFUN_CHECK_EN
        exp_inv = 1'b1;
`else
        exp_inv = 1'b0;
`endif
        run_fetch(64'h480, 80'h8967, 0, -1);
        checks++;
        if (!got_done || {instr_invalid, instr_valid, rA, rB, valP} !== {exp_inv, !exp_inv, 4'h8, 4'h9, 64'h482}) begin
            failures++; $display("FAIL ifun_67 got i=%b v=%b rA=%h rB=%h valP=%h exp i=%b",
                                 instr_invalid, instr_valid, rA, rB, valP, exp_inv);
        end
    endtask

    task automatic test_wrap();
        run_fetch('1, 80'h10, 0, -1);
        checks++;
        if (!got_done || valP !== 64'h0) begin
            failures++; $display("FAIL wrap_valp got valP=%h exp 0", valP);
        end
        mem[64'h0] = 8'h34;
        run_fetch('1, 80'h3420, 0, -1);
        checks++;
        if (!got_done || ack_q[base_ack + 1] !== 64'h0 || {rA, rB, valP} !== {4'h3, 4'h4, 64'h1}) begin
            failures++; $display("FAIL wrap_addr got addr1=%h rA=%h rB=%h valP=%h exp 0 3 4 1",
                                 ack_q[base_ack + 1], rA, rB, valP);
        end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 10; i++) mem[64'h600 + AW'(i)] = (i == 0) ? 8'h60 : (i == 1) ? 8'h12 : 8'h00;
        mem[64'h700] = 8'h10;
        ack_mode = 1; err_at = -1;
        @(negedge Clk);
        base_ack = acks_total; pc_in = 64'h600; start = 1'b1;
        @(negedge Clk);
        pc_in = 64'h700;
        got_done = 1'b0;
        for (int k = 0; k < 50 && !got_done; k++) begin
            if (done === 1'b1) got_done = 1'b1;
            else @(negedge Clk);
        end
        start = 1'b0;
        checks++;
        if (!got_done || {icode, rA, rB, valP} !== {4'h6, 4'h1, 4'h2, 64'h602}) begin
            failures++; $display("FAIL start_ignored got done=%b ic=%h rA=%h rB=%h valP=%h exp 6 1 2 602",
                                 got_done, icode, rA, rB, valP);
        end
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0 || acks_total - base_ack != 2) begin
            failures++; $display("FAIL start_in_done got busy=%b acks=%0d exp 0 2", busy, acks_total - base_ack);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) mem[64'h900 + AW'(i)] = (i == 0) ? 8'h30 : 8'h5A;
        ack_mode = 0; err_at = -1;
        @(negedge Clk);
        base_ack = acks_total; pc_in = 64'h900; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int k = 0; k < 50 && (acks_total - base_ack) < 4; k++) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({bus.imem_req, bus.imem_addr, busy, done, icode, ifun, rA, rB, valC, valP,
             instr_valid, instr_invalid, imem_err} !==
            {1'b0, 64'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got req=%b addr=%h busy=%b done=%b ic=%h rA=%h rB=%h valC=%h valP=%h",
                     bus.imem_req, bus.imem_addr, busy, done, icode, rA, rB, valC, valP);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset_start();
        Reset = 1'b1; start = 1'b1; pc_in = 64'h500;
        @(negedge Clk);
        Reset = 1'b0; start = 1'b0;
        @(negedge Clk);
        checks++;
        if ({busy, bus.imem_req} !== 2'b00) begin
            failures++; $display("FAIL reset_start got busy=%b req=%b exp 0 0", busy, bus.imem_req);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] p, vp;
        logic [79:0]   b;
        logic [3:0]    ra, rb;
        logic [63:0]   vc;
        logic          inv, eok;
        int            len, mode, eidx, ok, nack, bad_addr;
        for (int it = 0; it < 30; it++) begin
            p = {$urandom(), $urandom()};
            if (it % 7 == 3) p = '1 - AW'($urandom_range(0, 5));
            b = {$urandom(), $urandom(), 16'($urandom())};
            mode = $urandom_range(0, 2);
            model(p, b, 10, len, ra, rb, vc, vp, inv);
            eidx = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
            ok   = (eidx >= 0) ? eidx : len;
            nack = (eidx >= 0) ? eidx + 1 : len;
            model(p, b, ok, len, ra, rb, vc, vp, inv);
            run_fetch(p, b, mode, eidx);
            bad_addr = 0;
            for (int i = 0; i < nack && base_ack + i < ack_q.size(); i++)
                if (ack_q[base_ack + i] !== p + AW'(i)) bad_addr++;
            checks++;
            if (!got_done || acks_total - base_ack != nack || bad_addr != 0) begin
                failures++; $display("FAIL rnd%0d_handshake got done=%b acks=%0d badaddr=%0d exp acks=%0d",
                                     it, got_done, acks_total - base_ack, bad_addr, nack);
            end
            checks++;
            if (done_rel != last_ack_cyc - c0 + 1 || (mode == 0 && eidx < 0 && done_rel != len + 1)) begin
                failures++; $display("FAIL rnd%0d_latency got %0d last_ack=%0d len=%0d mode=%0d",
                                     it, done_rel, last_ack_cyc - c0, len, mode);
            end
            eok = (eidx < 0);
            checks++;
            if ({icode, ifun, rA, rB, valC, instr_invalid, imem_err, instr_valid} !==
                {b[7:4], b[3:0], ra, rb, vc, inv, !eok, eok && !inv} || (eok && valP !== vp)) begin
                failures++;
                $display("FAIL rnd%0d_fields got ic=%h fn=%h rA=%h rB=%h valC=%h valP=%h i=%b e=%b v=%b exp %h %h %h %h %h %h %b %b %b",
                         it, icode, ifun, rA, rB, valC, valP, instr_invalid, imem_err, instr_valid,
                         b[7:4], b[3:0], ra, rb, vc, vp, inv, !eok, eok && !inv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_irmovq_long();
        test_stall();
        test_error();
        test_invalid();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        test_reset_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
